ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_arb_pkg.sv | 13 +
 rtl/ram_port_arbiter_if.sv | 17 +
 rtl/ram_arb_grant.sv | 32 +++
 rtl/ram_port_arbiter.sv | 112 +++++++++++
 tb/tb_ram_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-requester RAM port-A arbiter.
// Optional feature macro: RAM_ARB_ROUND_ROBIN_EN (see ram_arb_grant / ram_port_arbiter).
package ram_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side bus of the RAM port arbiter: request/ack handshake plus
// word address, lane write enables and write/read data.
interface ram_port_arbiter_if #(
    parameter int NUM_COL    = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = NUM_COL * 8
);
    logic                  req;
    logic [ADDR_WIDTH-1:0] addr;
    logic [NUM_COL-1:0]    we;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ack;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output req, addr, we, wdata, input ack, rdata);
    modport slave  (input req, addr, we, wdata, output ack, rdata);
endinterface

// File: rtl/ram_arb_grant.sv
// Combinational grant selection: request vector in, one-hot grant out.
// Build macro RAM_ARB_ROUND_ROBIN_EN: ties go to the requester named by ptr
// (the one not granted last); otherwise m0 always wins a tie.
module ram_arb_grant
    import ram_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
`ifdef RAM_ARB_ROUND_ROBIN_EN
    input  logic               ptr,
`endif
    output logic [NUM_REQ-1:0] grant
);

    // Pick exactly one requester; a lone request is always granted directly
    always_comb begin
        grant = '0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        if (req[0] && req[1]) begin
            grant[ptr] = 1'b1;
        end else begin
            grant = req;
        end
`else
        if (req[0]) begin
            grant[0] = 1'b1;
        end else if (req[1]) begin
            grant[1] = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates two requesters onto RAM port A (port B belongs to instruction
// fetch). Fixed 3-cycle IDLE -> ACCESS -> RESP sequence per access.
// Build macro RAM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_COL    = 4,
    parameter int COL_WIDTH  = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = NUM_COL * COL_WIDTH
)(
    input  logic                  clk,
    input  logic                  rst_n,
    ram_port_arbiter_if.slave     m0,
    ram_port_arbiter_if.slave     m1,
    output logic [NUM_COL-1:0]    ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    state_t                state_reg;
    logic                  gnt_reg;        // 0 = m0 owns the access, 1 = m1
    logic [ADDR_WIDTH-1:0] lat_addr_reg;
    logic [NUM_COL-1:0]    lat_we_reg;
    logic [DATA_WIDTH-1:0] lat_wdata_reg;
    logic [NUM_REQ-1:0]    req_vec;
    logic [NUM_REQ-1:0]    grant_vec;
    logic                  access_en;
    logic                  resp_en;

    assign req_vec = {m1.req, m0.req};

`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic ptr_reg;                         // requester favoured on the next tie

    // Favour the other requester after every grant; m0 is favoured out of reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_reg <= 1'b0;
        end else if (state_reg == IDLE && |req_vec) begin
            ptr_reg <= grant_vec[0];
        end
    end

    ram_arb_grant u_grant (
        .req   (req_vec),
        .ptr   (ptr_reg),
        .grant (grant_vec)
    );
`else
    ram_arb_grant u_grant (
        .req   (req_vec),
        .grant (grant_vec)
    );
`endif

    // Sequencer: latch the winner's request in IDLE, hold it through RESP
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            gnt_reg       <= 1'b0;
            lat_addr_reg  <= '0;
            lat_we_reg    <= '0;
            lat_wdata_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|req_vec) begin
                        case (grant_vec)
                            2'b10: begin
                                gnt_reg       <= 1'b1;
                                lat_addr_reg  <= m1.addr;
                                lat_we_reg    <= m1.we;
                                lat_wdata_reg <= m1.wdata;
                            end
                            default: begin
                                gnt_reg       <= 1'b0;
                                lat_addr_reg  <= m0.addr;
                                lat_we_reg    <= m0.we;
                                lat_wdata_reg <= m0.wdata;
                            end
                        endcase
                        state_reg <= ACCESS;
                    end
                end
                ACCESS:  state_reg <= RESP;
                RESP:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // rst_n gates the strobes directly so a reset landing mid-access can
    // neither write the RAM nor complete the transaction
    assign access_en = (state_reg == ACCESS) && rst_n;
    assign resp_en   = (state_reg == RESP) && rst_n;

    assign ram_addr = lat_addr_reg;

    for (genvar gi = 0; gi < NUM_COL; gi++) begin : g_lane
        assign ram_we[gi]                          = access_en & lat_we_reg[gi];
        assign ram_din[gi*COL_WIDTH +: COL_WIDTH]  = lat_wdata_reg[gi*COL_WIDTH +: COL_WIDTH];
    end

    // RAM output is already registered; it lines up with the RESP cycle
    assign m0.ack   = resp_en & ~gnt_reg;
    assign m1.ack   = resp_en & gnt_reg;
    assign m0.rdata = ram_dout;
    assign m1.rdata = ram_dout;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios followed by
// randomized traffic, checked by a scoreboard fed from a transaction-level
// reference model. Honors RAM_ARB_ROUND_ROBIN_EN like the design.
module tb_ram_port_arbiter;

    localparam int AW = 12;
    localparam int NC = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NC-1:0] ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    always #5 clk = ~clk;

    ram_port_arbiter_if #(.NUM_COL(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_if ();
    ram_port_arbiter_if #(.NUM_COL(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_if ();

    ram_port_arbiter #(.NUM_COL(NC), .COL_WIDTH(8), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m0       (m0_if),
        .m1       (m1_if),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;   // index of the current clock period

    typedef struct {
        int          who;
        logic [31:0] rdata;
        int          period;
    } exp_t;

    exp_t sb[$];
    int   ack_who[$];
    int   ack_per[$];

    logic [31:0] ram_mem [0:(1<<AW)-1];
    logic [31:0] ref_mem [0:(1<<AW)-1];

    function automatic logic [31:0] init_word(input int i);
        return (32'h5A5A0000 ^ (i * 32'h01010101));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (period %0d)", name, act, exp, cyc);
        end
    endtask

    // RAM port A: registered read, read-first, byte-lane writes
    initial begin
        for (int i = 0; i < (1<<AW); i++) ram_mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            ram_dout <= ram_mem[ram_addr];
            for (int b = 0; b < NC; b++)
                if (ram_we[b]) ram_mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
        end
    end

    // Reference model: one transaction in flight; grant, then access, then response
    int          m_phase = 0;   // 0 free, 1 access cycle, 2 response cycle
    int          m_who;
    int          m_req_period;
    int          favoured = 0;
    logic [11:0] m_addr;
    logic [3:0]  m_we;
    logic [31:0] m_wdata;

    initial begin
        exp_t e;
        int   p;
        int   winner;
        for (int i = 0; i < (1<<AW); i++) ref_mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            p   = cyc;
            cyc = cyc + 1;
            if (!rst_n) begin
                m_phase  = 0;
                favoured = 0;
            end else if (m_phase == 0) begin
                if (m0_if.req || m1_if.req) begin
                    if (m0_if.req && m1_if.req) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
                        winner = favoured;
`else
                        winner = 0;
`endif
                    end else begin
                        winner = m0_if.req ? 0 : 1;
                    end
                    favoured = 1 - winner;
                    m_who    = winner;
                    m_addr   = (winner == 0) ? m0_if.addr  : m1_if.addr;
                    m_we     = (winner == 0) ? m0_if.we    : m1_if.we;
                    m_wdata  = (winner == 0) ? m0_if.wdata : m1_if.wdata;
                    m_req_period = p;
                    m_phase  = 1;
                end
            end else if (m_phase == 1) begin
                e.who    = m_who;
                e.rdata  = ref_mem[m_addr];
                e.period = m_req_period + 2;
                for (int b = 0; b < 4; b++)
                    if (m_we[b]) ref_mem[m_addr][b*8 +: 8] = m_wdata[b*8 +: 8];
                sb.push_back(e);
                m_phase = 2;
            end else begin
                m_phase = 0;
            end
        end
    end

    // Monitor: RAM strobes every period, acks popped against the scoreboard
    initial begin
        exp_t e;
        int   who;
        forever begin
            @(negedge clk);
            chk("ram_we", {28'd0, ram_we}, {28'd0, (m_phase == 1 && rst_n) ? m_we : 4'd0});
            if (m_phase == 1 && rst_n) begin
                chk("ram_addr", {20'd0, ram_addr}, {20'd0, m_addr});
                if (m_we != 4'd0) chk("ram_din", ram_din, m_wdata);
            end
            if (!rst_n) begin
                chk("ack_in_reset", {30'd0, m1_if.ack, m0_if.ack}, 32'd0);
            end else if (m0_if.ack || m1_if.ack) begin
                chk("ack_onehot", {31'd0, m0_if.ack & m1_if.ack}, 32'd0);
                who = m1_if.ack ? 1 : 0;
                ack_who.push_back(who);
                ack_per.push_back(cyc);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got ack from m%0d expected none (period %0d)", who, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("ack_who", who, e.who);
                    chk("ack_rdata", (who == 1) ? m1_if.rdata : m0_if.rdata, e.rdata);
                    chk("ack_period", cyc, e.period);
                end
            end else if (sb.size() > 0 && sb[0].period < cyc) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_ack: got none expected m%0d ack in period %0d", e.who, e.period);
            end
        end
    end

    task automatic drive(input int k, input logic [11:0] a, input logic [3:0] w, input logic [31:0] d);
        if (k == 0) begin
            m0_if.req = 1'b1; m0_if.addr = a; m0_if.we = w; m0_if.wdata = d;
        end else begin
            m1_if.req = 1'b1; m1_if.addr = a; m1_if.we = w; m1_if.wdata = d;
        end
    endtask

    task automatic drop(input int k);
        if (k == 0) m0_if.req = 1'b0;
        else        m1_if.req = 1'b0;
    endtask

    task automatic access(input int k, input logic [11:0] a, input logic [3:0] w,
                          input logic [31:0] d, output logic [31:0] rd);
        bit got;
        got = 1'b0;
        rd  = '0;
        @(negedge clk);
        drive(k, a, w, d);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if ((k == 0) ? m0_if.ack : m1_if.ack) begin
                got = 1'b1;
                rd  = (k == 0) ? m0_if.rdata : m1_if.rdata;
            end
        end
        drop(k);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL access_timeout: got no ack from m%0d expected one within 20 cycles", k);
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          n0;
        int          x;

        rst_n = 1'b0;
        m0_if.req = 1'b0; m0_if.addr = '0; m0_if.we = '0; m0_if.wdata = '0;
        m1_if.req = 1'b0; m1_if.addr = '0; m1_if.we = '0; m1_if.wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_ram_addr", {20'd0, ram_addr}, 32'd0);
        chk("reset_ram_din", ram_din, 32'd0);
        chk("reset_ram_we", {28'd0, ram_we}, 32'd0);
        rst_n = 1'b1;

        // Full write, then read back
        access(0, 12'h010, 4'hF, 32'hDEADBEEF, rd);
        access(0, 12'h010, 4'h0, 32'h0, rd);
        chk("m0_readback", rd, 32'hDEADBEEF);

        // Single-lane write from m1; write ack returns the pre-write word
        access(1, 12'h010, 4'b0010, 32'h0000AB00, rd);
        chk("m1_write_readfirst", rd, 32'hDEADBEEF);
        access(1, 12'h010, 4'h0, 32'h0, rd);
        chk("m1_lane_merge", rd, 32'hDEADABEF);

        // Both requesters held: arbitration order and 3-cycle spacing
        n0 = ack_who.size();
        @(negedge clk);
        drive(0, 12'h100, 4'h0, 32'h0);
        drive(1, 12'h101, 4'h0, 32'h0);
        repeat (12) @(negedge clk);
        drop(0);
        drop(1);
        repeat (6) @(negedge clk);
        chk("tie_ack_count_ge3", {31'd0, ack_who.size() >= n0 + 3}, 32'd1);
        if (ack_who.size() >= n0 + 3) begin
            chk("tie_first", ack_who[n0], 0);
`ifdef RAM_ARB_ROUND_ROBIN_EN
            chk("tie_second", ack_who[n0+1], 1);
`else
            chk("tie_second", ack_who[n0+1], 0);
`endif
            chk("tie_third", ack_who[n0+2], 0);
            chk("tie_spacing_1", ack_per[n0+1] - ack_per[n0], 3);
            chk("tie_spacing_2", ack_per[n0+2] - ack_per[n0+1], 3);
        end

        // Reset landing in the ACCESS cycle of a write
        access(0, 12'h020, 4'hF, 32'h11223344, rd);
        n0 = ack_who.size();
        @(negedge clk);
        drive(0, 12'h020, 4'hF, 32'hCAFEF00D);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        drop(0);
        repeat (2) @(negedge clk);
        chk("rst_mid_ram_addr", {20'd0, ram_addr}, 32'd0);
        chk("rst_mid_ram_din", ram_din, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_no_ack", ack_who.size(), n0);
        access(0, 12'h020, 4'h0, 32'h0, rd);
        chk("rst_write_blocked", rd, 32'h11223344);

        // m1 drops req in the cycle after grant; the access still completes
        n0 = ack_who.size();
        @(negedge clk);
        drive(1, 12'h030, 4'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        drop(1);
        repeat (5) @(negedge clk);
        chk("drop_ack_count", ack_who.size(), n0 + 1);
        if (ack_who.size() > n0) chk("drop_ack_who", ack_who[n0], 1);

        // Randomized traffic: fields may change while req is held
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                x = $urandom_range(0, 99);
                if (!((k == 0) ? m0_if.req : m1_if.req)) begin
                    if (x < 30)
                        drive(k, 12'($urandom_range(0, 15)),
                              ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                              $urandom);
                end else if ((k == 0) ? m0_if.ack : m1_if.ack) begin
                    if (x < 70) drop(k);
                    else drive(k, 12'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom);
                end else if (x < 3) begin
                    drop(k);
                end else if (x < 20) begin
                    drive(k, 12'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom);
                end
            end
        end
        drop(0);
        drop(1);
        for (int i = 0; i < 50 && (sb.size() != 0 || m_phase != 0); i++) @(negedge clk);
        @(negedge clk);
        chk("drain_scoreboard", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
